// File: rtl/proc_ctrl_fsm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// proc_ctrl_fsm_if : control/handshake bundle between controller and datapath
// Rev 1.0
// ---------------------------------------------------------------------------
interface proc_ctrl_fsm_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  run;
  logic [DATA_WIDTH-1:0] din;
  logic                  z_flag;
  logic [2:0]            bus_sel;
  logic [2:0]            rx_idx;
  logic [2:0]            ry_idx;
  logic                  reg_we;
  logic                  a_load;
  logic                  g_load;
  logic [1:0]            alu_op;
  logic                  addr_load;
  logic                  pc_incr;
  logic                  dout_load;
  logic                  mem_we;
  logic                  done;

  modport master (
    input  run, din, z_flag,
    output bus_sel, rx_idx, ry_idx, reg_we, a_load, g_load, alu_op,
           addr_load, pc_incr, dout_load, mem_we, done
  );

  modport slave (
    output run, din, z_flag,
    input  bus_sel, rx_idx, ry_idx, reg_we, a_load, g_load, alu_op,
           addr_load, pc_incr, dout_load, mem_we, done
  );
endinterface
`default_nettype wire

// File: rtl/proc_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// proc_ctrl_fsm : multicycle fetch/decode/execute controller for 16-bit core
// Rev 1.0
// ---------------------------------------------------------------------------
module proc_ctrl_fsm #(
  parameter int DATA_WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  proc_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    F1   = 3'd1,
    F2   = 3'd2,
    F3   = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  localparam logic [2:0] SEL_RX   = 3'b000;
  localparam logic [2:0] SEL_RY   = 3'b001;
  localparam logic [2:0] SEL_G    = 3'b010;
  localparam logic [2:0] SEL_DIN  = 3'b011;
  localparam logic [2:0] SEL_PC   = 3'b100;

  state_t                state;
  logic [DATA_WIDTH-1:0] ir;
  logic [2:0]            opcode;
  logic                  unused_ir_bits;

  assign opcode         = ir[DATA_WIDTH-1 -: 3];
  assign unused_ir_bits = &{1'b0, ir};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      case (state)
        IDLE: state <= bus.run ? F1 : IDLE;
        F1:   state <= F2;
        F2:   state <= F3;
        F3: begin
          ir    <= bus.din;
          state <= EX1;
        end
        EX1, EX2, EX3: begin
          // done marks the final cycle of every instruction; run is sampled only here
          if (bus.done)
            state <= bus.run ? F1 : IDLE;
          else if (state == EX1)
            state <= EX2;
          else if (state == EX2)
            state <= EX3;
          else
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.bus_sel   = 3'b000;
    bus.rx_idx    = 3'b000;
    bus.ry_idx    = 3'b000;
    bus.reg_we    = 1'b0;
    bus.a_load    = 1'b0;
    bus.g_load    = 1'b0;
    bus.alu_op    = 2'b00;
    bus.addr_load = 1'b0;
    bus.pc_incr   = 1'b0;
    bus.dout_load = 1'b0;
    bus.mem_we    = 1'b0;
    bus.done      = 1'b0;

    if (state == EX1 || state == EX2 || state == EX3) begin
      bus.rx_idx = ir[12:10];
      bus.ry_idx = ir[9:7];
    end

    case (state)
      F1: begin
        bus.bus_sel   = SEL_PC;
        bus.addr_load = 1'b1;
        bus.pc_incr   = 1'b1;
      end
      EX1: begin
        case (opcode)
          OP_MV: begin
            bus.bus_sel = SEL_RY;
            bus.reg_we  = 1'b1;
            bus.done    = 1'b1;
          end
          OP_MVNZ: begin
            bus.done = 1'b1;
            if (!bus.z_flag) begin
              bus.bus_sel = SEL_RY;
              bus.reg_we  = 1'b1;
            end
          end
          OP_MVI: begin
            bus.bus_sel   = SEL_PC;
            bus.addr_load = 1'b1;
            bus.pc_incr   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            bus.bus_sel = SEL_RX;
            bus.a_load  = 1'b1;
          end
          OP_LD, OP_ST: begin
            bus.bus_sel   = SEL_RY;
            bus.addr_load = 1'b1;
          end
          default: ;
        endcase
      end
      EX2: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            bus.bus_sel = SEL_RY;
            bus.g_load  = 1'b1;
            bus.alu_op  = (opcode == OP_SUB) ? 2'b01 :
                          (opcode == OP_AND) ? 2'b10 : 2'b00;
          end
          OP_ST: begin
            bus.bus_sel   = SEL_RX;
            bus.dout_load = 1'b1;
            bus.mem_we    = 1'b1;
            bus.done      = 1'b1;
          end
          default: ;
        endcase
      end
      EX3: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            bus.bus_sel = SEL_G;
            bus.reg_we  = 1'b1;
            bus.done    = 1'b1;
          end
          OP_MVI, OP_LD: begin
            bus.bus_sel = SEL_DIN;
            bus.reg_we  = 1'b1;
            bus.done    = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_ctrl_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_proc_ctrl_fsm : directed self-checking bench for proc_ctrl_fsm
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_proc_ctrl_fsm;

  // Flag masks for the 10 low bits of the observed control vector
  localparam logic [9:0] RW  = 10'b10_0000_0000;
  localparam logic [9:0] AL  = 10'b01_0000_0000;
  localparam logic [9:0] GL  = 10'b00_1000_0000;
  localparam logic [9:0] AND = 10'b00_0100_0000;
  localparam logic [9:0] SUB = 10'b00_0010_0000;
  localparam logic [9:0] ADL = 10'b00_0001_0000;
  localparam logic [9:0] PCI = 10'b00_0000_1000;
  localparam logic [9:0] DOL = 10'b00_0000_0100;
  localparam logic [9:0] MWE = 10'b00_0000_0010;
  localparam logic [9:0] DN  = 10'b00_0000_0001;
  localparam logic [9:0] NONE = 10'b0;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  proc_ctrl_fsm_if #(.DATA_WIDTH(16)) bus ();

  proc_ctrl_fsm #(.DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [2:0] bs, input logic [9:0] flags);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {bus.bus_sel, bus.reg_we, bus.a_load, bus.g_load, bus.alu_op,
           bus.addr_load, bus.pc_incr, bus.dout_load, bus.mem_we, bus.done};
    exp = {bs, flags};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idx(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag);
    cyc(); chk({tag, "_f1"}, 3'b100, ADL | PCI);
    cyc(); chk({tag, "_f2"}, 3'b000, NONE);
    cyc(); chk({tag, "_f3"}, 3'b000, NONE);
  endtask

  initial begin
    reset      = 1'b1;
    bus.run    = 1'b0;
    bus.din    = 16'h0000;
    bus.z_flag = 1'b0;
    cyc(); cyc();
    chk("reset", 3'b000, NONE);
    chk_idx("reset_rx", bus.rx_idx, 3'd0);

    // mvi r1, #0x00AB
    reset   = 1'b0;
    bus.run = 1'b1;
    bus.din = 16'h2400;
    fetch("mvi");
    cyc(); chk("mvi_ex1", 3'b100, ADL | PCI);
    bus.din = 16'h00AB;
    cyc(); chk("mvi_ex2", 3'b000, NONE);
    cyc(); chk("mvi_ex3", 3'b011, RW | DN);
    chk_idx("mvi_rx", bus.rx_idx, 3'd1);

    // add r2, r3
    bus.din = 16'h4980;
    fetch("add");
    cyc(); chk("add_ex1", 3'b000, AL);
    chk_idx("add_rx", bus.rx_idx, 3'd2);
    cyc(); chk("add_ex2", 3'b001, GL);
    chk_idx("add_ry", bus.ry_idx, 3'd3);
    cyc(); chk("add_ex3", 3'b010, RW | DN);
    chk_idx("add_rx3", bus.rx_idx, 3'd2);

    // sub r2, r3
    bus.din = 16'h6980;
    fetch("sub");
    cyc(); chk("sub_ex1", 3'b000, AL);
    cyc(); chk("sub_ex2", 3'b001, GL | SUB);
    cyc(); chk("sub_ex3", 3'b010, RW | DN);

    // and r2, r3
    bus.din = 16'hE980;
    fetch("and");
    cyc(); chk("and_ex1", 3'b000, AL);
    cyc(); chk("and_ex2", 3'b001, GL | AND);
    cyc(); chk("and_ex3", 3'b010, RW | DN);

    // st r1, [r4]
    bus.din = 16'hA600;
    fetch("st");
    cyc(); chk("st_ex1", 3'b001, ADL);
    cyc(); chk("st_ex2", 3'b000, DOL | MWE | DN);
    chk_idx("st_rx", bus.rx_idx, 3'd1);

    // mvnz r0, r5 with Z set, then with Z clear
    bus.din    = 16'hC280;
    bus.z_flag = 1'b1;
    fetch("mvnz1");
    cyc(); chk("mvnz_z1", 3'b000, DN);
    bus.z_flag = 1'b0;
    fetch("mvnz0");
    cyc(); chk("mvnz_z0", 3'b001, RW | DN);
    chk_idx("mvnz_ry", bus.ry_idx, 3'd5);

    // mv r0, r5 then ld r2, [r4] with run dropped at ld EX1
    bus.din = 16'h0280;
    fetch("mv");
    cyc(); chk("mv_ex1", 3'b001, RW | DN);
    bus.din = 16'h8A00;
    fetch("ld");
    cyc(); chk("ld_ex1", 3'b001, ADL);
    bus.run = 1'b0;
    cyc(); chk("ld_ex2", 3'b000, NONE);
    cyc(); chk("ld_ex3", 3'b011, RW | DN);
    chk_idx("ld_rx", bus.rx_idx, 3'd2);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("idle_after_ld", 3'b000, NONE);
      chk_idx("idle_rx", bus.rx_idx, 3'd0);
    end

    // reset asserted during add EX2
    bus.run = 1'b1;
    bus.din = 16'h4980;
    fetch("add_rst");
    cyc(); chk("add_rst_ex1", 3'b000, AL);
    cyc(); chk("add_rst_ex2", 3'b001, GL);
    reset = 1'b1;
    cyc(); chk("after_reset", 3'b000, NONE);
    chk_idx("after_reset_rx", bus.rx_idx, 3'd0);
    reset = 1'b0;
    cyc(); chk("restart_f1", 3'b100, ADL | PCI);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
